// File: rtl/relay_seq_pkg.sv
// Shared types and helpers for the relay sequencer.
package relay_seq_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    ON   = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [1:0] RELAY_NONE = 2'd0;

  // Relay index (1..3) to one-hot drive pattern; index 0 means all off.
  function automatic logic [2:0] onehot3(input logic [1:0] sel);
    logic [2:0] res;
    res = 3'b000;
    case (sel)
      2'd1:    res = 3'b001;
      2'd2:    res = 3'b010;
      2'd3:    res = 3'b100;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Debounces the 2-bit relay request: a value must be seen on
// STABLE_CYC+1 consecutive edges before it is accepted on dout.
module sel_debounce #(
  parameter int STABLE_CYC = 3,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYC - 1);

  logic [1:0]       cand;
  logic [CNT_W-1:0] stab_cnt;

  // Track the candidate value and how long it has been stable; accept it once stable long enough.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand     <= 2'd0;
      stab_cnt <= '0;
      dout     <= 2'd0;
    end else if (din != cand) begin
      cand     <= din;
      stab_cnt <= '0;
    end else if (stab_cnt < STAB_LAST) begin
      stab_cnt <= stab_cnt + CNT_W'(1);
    end else begin
      dout <= cand;
    end
  end

endmodule

// File: rtl/relay_sequencer.sv
// Break-before-make relay sequencer: debounced request, minimum on-time,
// dead time between any break and the next make, one-hot relay drive.
module relay_sequencer #(
  parameter int STABLE_CYC = 3,
  parameter int MIN_ON_CYC = 16,
  parameter int DEAD_CYC   = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] relay_sel,
  output logic [2:0] relay_en,
  output logic       busy,
  output logic [7:0] switch_cnt
);

  import relay_seq_pkg::*;

  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] ON_MAX    = CNT_W'(MIN_ON_CYC);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);

  state_t           state;
  logic [1:0]       acc;
  logic [1:0]       cur;
  logic [1:0]       eff;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] dead_cnt;

  sel_debounce #(
    .STABLE_CYC(STABLE_CYC),
    .CNT_W     (CNT_W)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .din (relay_sel),
    .dout(acc)
  );

  // ena gates the accepted request directly; it is not debounced.
  assign eff = ena ? acc : RELAY_NONE;

  // Sequencer FSM: make, hold for the minimum on-time, break, wait out the dead time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      cur        <= RELAY_NONE;
      on_cnt     <= '0;
      dead_cnt   <= '0;
      relay_en   <= 3'b000;
      busy       <= 1'b0;
      switch_cnt <= 8'd0;
    end else begin
      case (state)
        OFF: begin
          busy <= 1'b0;
          if (eff != RELAY_NONE) begin
            cur        <= eff;
            on_cnt     <= '0;
            relay_en   <= onehot3(eff);
            switch_cnt <= switch_cnt + 8'd1;
            state      <= ON;
          end else begin
            relay_en <= 3'b000;
          end
        end

        ON: begin
          if (on_cnt < ON_MAX) on_cnt <= on_cnt + CNT_W'(1);
          if (eff != cur && on_cnt >= ON_LAST) begin
            relay_en <= 3'b000;
            dead_cnt <= '0;
            busy     <= 1'b1;
            state    <= DEAD;
          end else begin
            relay_en <= onehot3(cur);
            busy     <= (eff != cur);
          end
        end

        DEAD: begin
          relay_en <= 3'b000;
          if (dead_cnt == DEAD_LAST) begin
            busy <= 1'b0;
            if (eff != RELAY_NONE) begin
              cur        <= eff;
              on_cnt     <= '0;
              relay_en   <= onehot3(eff);
              switch_cnt <= switch_cnt + 8'd1;
              state      <= ON;
            end else begin
              state <= OFF;
            end
          end else begin
            dead_cnt <= dead_cnt + CNT_W'(1);
            busy     <= 1'b1;
          end
        end

        default: begin
          relay_en <= 3'b000;
          busy     <= 1'b0;
          state    <= OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relay_sequencer.sv
// Self-checking bench for relay_sequencer: directed scenarios plus random
// stimulus, scored every cycle against a timestamp-based reference model.
module tb_relay_sequencer;

  localparam int STABLE_CYC = 3;
  localparam int MIN_ON_CYC = 16;
  localparam int DEAD_CYC   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [1:0] relay_sel;
  logic [2:0] relay_en;
  logic       busy;
  logic [7:0] switch_cnt;

  int errors = 0;
  int checks = 0;

  relay_sequencer #(
    .STABLE_CYC(STABLE_CYC),
    .MIN_ON_CYC(MIN_ON_CYC),
    .DEAD_CYC  (DEAD_CYC),
    .CNT_W     (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .relay_sel (relay_sel),
    .relay_en  (relay_en),
    .busy      (busy),
    .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: sample history for debounce, absolute edge times for on/dead windows.
  logic [1:0] hist[$];
  logic [1:0] m_acc;
  logic [1:0] m_cur;
  bit         m_on;
  bit         m_dead;
  int         m_make_t;
  int         m_break_t;
  logic [7:0] m_switch;
  bit         m_busy;
  int         t = 0;

  task automatic model_make(input logic [1:0] eff);
    m_on     = 1'b1;
    m_cur    = eff;
    m_make_t = t;
    m_switch = m_switch + 8'd1;
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [1:0] s);
    logic [1:0] eff;
    bit same;
    t++;
    if (r) begin
      hist.delete();
      hist.push_back(2'd0);
      m_acc = 2'd0; m_cur = 2'd0; m_on = 0; m_dead = 0;
      m_switch = 8'd0; m_busy = 0;
      return;
    end
    eff = e ? m_acc : 2'd0;
    if (m_on) begin
      if (eff != m_cur && (t - m_make_t) >= MIN_ON_CYC) begin
        m_on = 0; m_dead = 1; m_break_t = t;
      end
    end else if (m_dead) begin
      if ((t - m_break_t) >= DEAD_CYC) begin
        m_dead = 0;
        if (eff != 2'd0) model_make(eff);
      end
    end else if (eff != 2'd0) begin
      model_make(eff);
    end
    m_busy = m_dead || (m_on && eff != m_cur);
    hist.push_back(s);
    if (hist.size() > STABLE_CYC + 1) void'(hist.pop_front());
    if (hist.size() == STABLE_CYC + 1) begin
      same = 1;
      foreach (hist[i]) if (hist[i] != s) same = 0;
      if (same) m_acc = s;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic r, input logic e, input logic [1:0] s);
    logic [2:0] exp_en;
    rst = r; ena = e; relay_sel = s;
    @(posedge clk);
    model_edge(r, e, s);
    #1;
    exp_en = m_on ? 3'(1 << (int'(m_cur) - 1)) : 3'b000;
    checks++;
    if (relay_en !== exp_en) begin
      errors++;
      $display("FAIL relay_en t=%0d got=%b exp=%b", t, relay_en, exp_en);
    end
    checks++;
    if (busy !== m_busy) begin
      errors++;
      $display("FAIL busy t=%0d got=%b exp=%b", t, busy, m_busy);
    end
    checks++;
    if (switch_cnt !== m_switch) begin
      errors++;
      $display("FAIL switch_cnt t=%0d got=%0d exp=%0d", t, switch_cnt, m_switch);
    end
    checks++;
    if ($countones(relay_en) > 1) begin
      errors++;
      $display("FAIL onehot t=%0d got=%b exp=popcount<=1", t, relay_en);
    end
  endtask

  task automatic wait_en(input logic [2:0] want, input logic e, input logic [1:0] s);
    int n = 0;
    while (relay_en !== want && n < 64) begin
      step(1'b0, e, s);
      n++;
    end
    checks++;
    if (relay_en !== want) begin
      errors++;
      $display("FAIL wait_en got=%b exp=%b", relay_en, want);
    end
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 2'd3);
    step(1'b1, 1'b1, 2'd3);
    checks++;
    if (relay_en !== 3'b000 || busy !== 1'b0 || switch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_hold got=%b/%b/%0d exp=000/0/0", relay_en, busy, switch_cnt);
    end
    step(1'b0, 1'b1, 2'd3);
    checks++;
    if (relay_en !== 3'b000 || busy !== 1'b0 || switch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_release got=%b/%b/%0d exp=000/0/0", relay_en, busy, switch_cnt);
    end
  endtask

  task automatic test_make;
    step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd1);
    checks++;
    if (relay_en !== 3'b000) begin
      errors++;
      $display("FAIL make_early got=%b exp=000", relay_en);
    end
    step(1'b0, 1'b1, 2'd1);
    checks++;
    if (relay_en !== 3'b001 || switch_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL make got=%b/%0d/%b exp=001/1/0", relay_en, switch_cnt, busy);
    end
  endtask

  // Continues from test_make with relay 1 just made.
  task automatic test_switch;
    int on_n = 1;
    int off_n = 0;
    while (relay_en === 3'b001 && on_n < 64) begin
      step(1'b0, 1'b1, 2'd3);
      if (relay_en === 3'b001) on_n++;
    end
    while (relay_en === 3'b000 && off_n < 64) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL switch_dead_busy got=%b exp=1", busy);
      end
      off_n++;
      step(1'b0, 1'b1, 2'd3);
    end
    checks++;
    if (on_n != MIN_ON_CYC) begin
      errors++;
      $display("FAIL switch_on_len got=%0d exp=%0d", on_n, MIN_ON_CYC);
    end
    checks++;
    if (off_n != DEAD_CYC) begin
      errors++;
      $display("FAIL switch_dead_len got=%0d exp=%0d", off_n, DEAD_CYC);
    end
    checks++;
    if (relay_en !== 3'b100 || switch_cnt !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL switch_make got=%b/%0d/%b exp=100/2/0", relay_en, switch_cnt, busy);
    end
  endtask

  task automatic test_glitch;
    step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'd0);
    checks++;
    if (relay_en !== 3'b000 || switch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch got=%b/%0d exp=000/0", relay_en, switch_cnt);
    end
  endtask

  task automatic test_ena_drop;
    step(1'b1, 1'b1, 2'd2);
    wait_en(3'b010, 1'b1, 2'd2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd2);
    checks++;
    if (relay_en !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ena_break got=%b/%b exp=000/1", relay_en, busy);
    end
    for (int i = 0; i < DEAD_CYC; i++) step(1'b0, 1'b0, 2'd2);
    checks++;
    if (relay_en !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ena_off got=%b/%b exp=000/0", relay_en, busy);
    end
    step(1'b0, 1'b1, 2'd2);
    checks++;
    if (relay_en !== 3'b010 || switch_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ena_remake got=%b/%0d exp=010/2", relay_en, switch_cnt);
    end
  endtask

  task automatic test_reset_mid;
    step(1'b1, 1'b1, 2'd1);
    wait_en(3'b001, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b1, 2'd1);
    checks++;
    if (relay_en !== 3'b000 || switch_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_on got=%b/%0d/%b exp=000/0/0", relay_en, switch_cnt, busy);
    end
    wait_en(3'b001, 1'b1, 2'd1);
    wait_en(3'b000, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b1, 2'd2);
    checks++;
    if (relay_en !== 3'b000 || switch_cnt !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_dead got=%b/%0d/%b exp=000/0/0", relay_en, switch_cnt, busy);
    end
    step(1'b0, 1'b1, 2'd2);
  endtask

  task automatic test_wrap;
    logic [7:0] start;
    int n;
    step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 256; i++) begin
      start = m_switch;
      n = 0;
      while (m_switch == start && n < 64) begin
        step(1'b0, 1'b1, 2'((i % 3) + 1));
        n++;
      end
    end
    checks++;
    if (switch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap got=%0d exp=0", switch_cnt);
    end
  endtask

  task automatic test_random;
    logic [1:0] s;
    logic e;
    int hold;
    step(1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 200; i++) begin
      s = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 7) != 0);
      hold = $urandom_range(1, 30);
      for (int j = 0; j < hold; j++) step(1'b0, e, s);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; relay_sel = 2'd0;
    test_reset;
    test_make;
    test_switch;
    test_glitch;
    test_ena_drop;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
